uart_tx: RTL and testbench

- Serial transmitter that drives the host-facing UART TX line.
- Consumes the byte-stream output handshake (enable / data / busy) produced by puzzle-style solver blocks.
- Generates the busy signal those blocks wait on, and frames each accepted byte as start bit, 8 data bits LSB-first, optional parity, and 1 or 2 stop bits.
- Sits between the solver's output port and the board TX pin.

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity,
// and 1 or 2 stop bits, fed by an enable/data/busy byte handshake.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       txd
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);
    localparam logic ODD = (PARITY == 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          txd_q;
    logic          busy_q;
    logic          wrap;

    assign wrap    = (baud_q == BAUD_MAX);
    assign txd     = txd_q;
    assign tx_busy = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            if (state_q != IDLE) begin
                baud_q <= wrap ? '0 : baud_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (tx_en) begin
                        state_q <= START;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        shift_q <= tx_data;
                        // parity frozen from the accepted byte, not the shifter
                        par_q   <= (^tx_data) ^ ODD;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end
                end
                START: begin
                    if (wrap) begin
                        state_q <= DATA;
                        txd_q   <= shift_q[0];
                    end
                end
                DATA: begin
                    if (wrap) begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                state_q <= PAR;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= shift_q[1];
                        end
                    end
                end
                PAR: begin
                    if (wrap) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        if (bit_q == STOP_MAX) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parity/stop configurations at 4 clocks per bit,
// each tracked cycle by cycle against a frame-level reference model.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [3:0] busy;
    logic [3:0] txd;

    int n_vec = 0;
    int n_err = 0;
    bit chk   = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(busy[0]), .txd(txd[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(busy[1]), .txd(txd[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(busy[2]), .txd(txd[2]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_data(tx_data),
        .tx_busy(busy[3]), .txd(txd[3]));

    function automatic int par_of(int i);
        case (i)
            1: return 2;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int flen(int i);
        return CPB * (9 + ((par_of(i) != 0) ? 1 : 0) + stop_of(i));
    endfunction

    // Line level of serial bit k of a frame carrying d.
    function automatic logic ref_bit(int i, logic [7:0] d, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && par_of(i) == 2) return ^d;
        if (k == 9 && par_of(i) == 1) return ~(^d);
        return 1'b1;
    endfunction

    bit         act [4];
    int         el  [4];
    logic [7:0] dat [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                act[i] = 1'b0;
            end else if (act[i]) begin
                el[i] = el[i] + 1;
                if (el[i] == flen(i)) act[i] = 1'b0;
            end else if (tx_en) begin
                act[i] = 1'b1;
                el[i]  = 0;
                dat[i] = tx_data;
            end
        end
    end

    task automatic check(string name, int got, int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model busy[%0d]", i), int'(busy[i]), int'(act[i]));
                check($sformatf("model txd[%0d]", i), int'(txd[i]),
                      act[i] ? int'(ref_bit(i, dat[i], el[i] / CPB)) : 1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy != 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle wait", int'(busy), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         cfg;
        int         width;
        bit         chk_par;
        logic       par;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int w;
        int g;

        tbl[0] = '{8'h41, 0, 40, 1'b0, 1'b0};
        tbl[1] = '{8'h41, 1, 44, 1'b1, 1'b0};
        tbl[2] = '{8'h41, 2, 44, 1'b1, 1'b1};
        tbl[3] = '{8'h07, 1, 44, 1'b1, 1'b1};
        tbl[4] = '{8'hFF, 3, 44, 1'b0, 1'b0};

        rst     = 1'b1;
        tx_en   = 1'b0;
        tx_data = 8'h00;
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset txd", int'(txd), 15);
        chk = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            wait_idle();
            tx_en   = 1'b1;
            tx_data = tbl[k].data;
            @(negedge clk);
            tx_en = 1'b0;
            w = 0;
            while (busy[tbl[k].cfg] && w < 200) begin
                if (tbl[k].chk_par && w == 37)
                    check($sformatf("parity vec%0d", k), int'(txd[tbl[k].cfg]), int'(tbl[k].par));
                w++;
                @(negedge clk);
            end
            check($sformatf("busy width vec%0d", k), w, tbl[k].width);
        end

        // Held enable: second byte goes out after exactly one idle cycle.
        wait_idle();
        tx_en   = 1'b1;
        tx_data = 8'h30;
        @(negedge clk);
        tx_data = 8'h0A;
        w = 0;
        while (busy[0] && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("b2b width", w, 40);
        g = 0;
        while (!busy[0] && g < 10) begin
            check("b2b gap txd", int'(txd[0]), 1);
            g++;
            @(negedge clk);
        end
        check("b2b gap", g, 1);
        tx_en = 1'b0;

        // Data changed while busy must not disturb the frame in flight.
        wait_idle();
        tx_en   = 1'b1;
        tx_data = 8'h55;
        @(negedge clk);
        tx_data = 8'h00;
        w = 0;
        while (busy[0] && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("hold width", w, 40);
        g = 0;
        while (!busy[0] && g < 10) begin
            g++;
            @(negedge clk);
        end
        check("hold gap", g, 1);
        tx_en = 1'b0;

        // Reset during data bit 3, with a competing enable.
        wait_idle();
        tx_en   = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        tx_en = 1'b0;
        repeat (17) @(negedge clk);
        rst     = 1'b1;
        tx_en   = 1'b1;
        tx_data = 8'hEE;
        @(negedge clk);
        rst   = 1'b0;
        tx_en = 1'b0;
        check("rst busy", int'(busy), 0);
        check("rst txd", int'(txd), 15);
        @(negedge clk);
        check("rst no accept", int'(busy), 0);
        tx_en   = 1'b1;
        tx_data = 8'h5A;
        @(negedge clk);
        tx_en = 1'b0;
        w = 0;
        while (busy[0] && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("post rst width", w, 40);
        wait_idle();

        repeat (3000) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 299) == 0);
            tx_en   = ($urandom_range(0, 2) == 0);
            tx_data = 8'($urandom);
        end
        @(negedge clk);
        rst   = 1'b0;
        tx_en = 1'b0;
        wait_idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
